dmem_resp: RTL and testbench



---
 rtl/dmem_resp.sv | 81 ++++++++
 tb/tb_dmem_resp.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_resp.sv
// dmem_resp: word-organised data RAM responder with byte-lane writes, wait states, pipeline hold and range error
//   clk, rstn      core clock, asynchronous active-low reset
//   cs_i, we_i     access request valid this cycle, 1 = write / 0 = read
//   wem_i          byte-lane write enables, bit k covers din_i[8k+7:8k]
//   addr_i, din_i  byte address (bits [1:0] ignored), write data
//   dout_o         registered read data
//   err_o          registered one-cycle pulse after an out-of-range access completes
//   hold_o         combinational stall request to ctrl while the access is waiting
module dmem_resp #(
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
   parameter int unsigned WAIT_CYC    = 0
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        cs_i,
   input  logic        we_i,
   input  logic [3:0]  wem_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] din_i,
   output logic [31:0] dout_o,
   output logic        err_o,
   output logic        hold_o
);
   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam int unsigned CW = WAIT_CYC == 0 ? 1 : $clog2(WAIT_CYC + 1);
   typedef enum logic {IDLE, WAIT} state_t;
   state_t        state, nxt_state;
   logic [CW-1:0] cnt, nxt_cnt;
   logic [31:0]   mem [DEPTH_WORDS];
   logic [AW-1:0] idx;
   logic          in_range, stall, go, commit;
   assign idx = AW'((addr_i - BASE_ADDR) >> 2);
   // 33-bit compare so a window ending exactly at 2^32 does not wrap to zero
   assign in_range = ({1'b0, addr_i} >= {1'b0, BASE_ADDR}) &&
                     ({1'b0, addr_i} < {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2));
   // while reset is asserted nothing may stall the pipeline or commit
   assign hold_o = stall & rstn;
   assign commit = go & rstn;
   always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt;
      stall     = 1'b0;
      go        = 1'b0;
      if (state == IDLE) begin
         if (cs_i && WAIT_CYC == 0) go = 1'b1;
         else if (cs_i) begin
            stall     = 1'b1;
            nxt_state = WAIT;
            nxt_cnt   = CW'(WAIT_CYC - 1);
         end
      end else if (!cs_i) begin
         nxt_state = IDLE;
         nxt_cnt   = '0;
      end else if (cnt != '0) begin
         stall   = 1'b1;
         nxt_cnt = cnt - 1'b1;
      end else begin
         go        = 1'b1;
         nxt_state = IDLE;
      end
   end
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state  <= IDLE;
         cnt    <= '0;
         dout_o <= '0;
         err_o  <= 1'b0;
      end else begin
         state <= nxt_state;
         cnt   <= nxt_cnt;
         err_o <= commit & ~in_range;
         if (commit && !we_i) dout_o <= in_range ? mem[idx] : '0;
      end
   end
   always_ff @(posedge clk) begin
      if (commit && we_i && in_range)
         for (int k = 0; k < 4; k++)
            if (wem_i[k]) mem[idx][8*k +: 8] <= din_i[8*k +: 8];
   end
endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: randomized transaction-level check of dmem_resp against a word-array reference model
module tb_dmem_resp;
   localparam int unsigned DW = 16;
   localparam logic [31:0] B  = 32'h1000_0000;
   localparam logic [31:0] HB = 32'hFFFF_FFC0;
   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [3:0]  cs = '0;
   logic        we = 1'b0;
   logic [3:0]  wem = '0;
   logic [31:0] addr = '0;
   logic [31:0] din = '0;
   logic [31:0] dout [4];
   logic [3:0]  err, hold;
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   logic [31:0] rm [4][DW];
   logic [31:0] exp_dout [4];
   bit          last_oor [4];
   int          last_cc [4];
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   dmem_resp #(.DEPTH_WORDS(DW), .BASE_ADDR(B), .WAIT_CYC(0)) u0 (
      .clk(clk), .rstn(rstn), .cs_i(cs[0]), .we_i(we), .wem_i(wem), .addr_i(addr), .din_i(din),
      .dout_o(dout[0]), .err_o(err[0]), .hold_o(hold[0]));
   dmem_resp #(.DEPTH_WORDS(DW), .BASE_ADDR(B), .WAIT_CYC(2)) u1 (
      .clk(clk), .rstn(rstn), .cs_i(cs[1]), .we_i(we), .wem_i(wem), .addr_i(addr), .din_i(din),
      .dout_o(dout[1]), .err_o(err[1]), .hold_o(hold[1]));
   dmem_resp #(.DEPTH_WORDS(DW), .BASE_ADDR(B), .WAIT_CYC(3)) u2 (
      .clk(clk), .rstn(rstn), .cs_i(cs[2]), .we_i(we), .wem_i(wem), .addr_i(addr), .din_i(din),
      .dout_o(dout[2]), .err_o(err[2]), .hold_o(hold[2]));
   dmem_resp #(.DEPTH_WORDS(DW), .BASE_ADDR(HB), .WAIT_CYC(0)) u3 (
      .clk(clk), .rstn(rstn), .cs_i(cs[3]), .we_i(we), .wem_i(wem), .addr_i(addr), .din_i(din),
      .dout_o(dout[3]), .err_o(err[3]), .hold_o(hold[3]));
   function automatic int unsigned wait_of(input int i);
      return i == 1 ? 2 : i == 2 ? 3 : 0;
   endfunction
   function automatic logic [31:0] base_of(input int i);
      return i == 3 ? HB : B;
   endfunction
   // err is expected only in the cycle right after an out-of-range commit
   function automatic bit exp_err(input int i);
      return cyc == last_cc[i] && last_oor[i];
   endfunction
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask
   // starts at negedge+1, returns at negedge+1 of the cycle after the commit with cs still high
   task automatic access(input int i, input bit w, input logic [3:0] m, input logic [31:0] a, input logic [31:0] d);
      int hc, k;
      longint unsigned aa, bb;
      bit ok;
      cs = '0;
      cs[i] = 1'b1;
      we = w;
      wem = m;
      addr = a;
      din = d;
      hc = 0;
      #3;
      while (hold[i] === 1'b1 && hc < 20) begin
         chk("err_hold", 32'(err[i]), 32'(exp_err(i)));
         hc++;
         @(posedge clk);
         @(negedge clk);
         #4;
      end
      chk("err_pre", 32'(err[i]), 32'(exp_err(i)));
      chk("hold_cycles", 32'(hc), 32'(wait_of(i)));
      @(posedge clk);
      @(negedge clk);
      #1;
      aa = a;
      bb = base_of(i);
      ok = aa >= bb && aa < bb + 4 * DW;
      k = ok ? int'((aa - bb) / 4) : 0;
      if (ok && w) begin
         for (int b = 0; b < 4; b++)
            if (m[b]) rm[i][k][8*b +: 8] = d[8*b +: 8];
      end else if (!w) exp_dout[i] = ok ? rm[i][k] : 32'h0;
      last_cc[i] = cyc;
      last_oor[i] = !ok;
      chk("dout", dout[i], exp_dout[i]);
      chk("err", 32'(err[i]), 32'(!ok));
   endtask
   task automatic idle(input int n);
      cs = '0;
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
         #1;
         for (int j = 0; j < 4; j++) begin
            chk("idle_err", 32'(err[j]), 32'(exp_err(j)));
            chk("idle_hold", 32'(hold[j]), 32'h0);
            chk("idle_dout", dout[j], exp_dout[j]);
         end
      end
   endtask
   initial begin
      int i, sel;
      logic [31:0] a;
      for (int j = 0; j < 4; j++) begin
         exp_dout[j] = '0;
         last_oor[j] = 1'b0;
         last_cc[j] = -1;
      end
      cs[2] = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      for (int j = 0; j < 4; j++) begin
         chk("rst_dout", dout[j], 32'h0);
         chk("rst_err", 32'(err[j]), 32'h0);
         chk("rst_hold", 32'(hold[j]), 32'h0);
      end
      cs = '0;
      rstn = 1'b1;
      @(negedge clk);
      #1;
      for (int j = 0; j < 4; j++)
         for (int w = 0; w < int'(DW); w++)
            access(j, 1'b1, 4'hF, base_of(j) + 32'(4 * w), $urandom);
      idle(2);
      access(0, 1'b1, 4'hF, B + 32'd8, 32'hDEADBEEF);
      access(0, 1'b0, 4'h0, B + 32'd8, 32'h0);
      chk("rd_deadbeef", dout[0], 32'hDEADBEEF);
      access(0, 1'b1, 4'hF, B + 32'd4, 32'h11223344);
      access(0, 1'b1, 4'b0101, B + 32'd4, 32'hAABBCCDD);
      access(0, 1'b0, 4'h0, B + 32'd4, 32'h0);
      chk("byte_mask", dout[0], 32'h11BB33DD);
      idle(1);
      access(2, 1'b1, 4'hF, B, 32'h5);
      idle(1);
      access(2, 1'b0, 4'h0, B, 32'h0);
      chk("wait3_rd", dout[2], 32'h5);
      idle(1);
      access(0, 1'b0, 4'h0, B + 32'(4 * DW), 32'h0);
      chk("oor_rd_dout", dout[0], 32'h0);
      chk("oor_rd_err", 32'(err[0]), 32'h1);
      idle(1);
      access(0, 1'b1, 4'hF, B - 32'd4, 32'hFFFF_FFFF);
      chk("oor_wr_err", 32'(err[0]), 32'h1);
      access(0, 1'b0, 4'h0, B + 32'(4 * DW - 4), 32'h0);
      chk("oor_wr_top", dout[0], rm[0][DW-1]);
      access(3, 1'b0, 4'h0, HB + 32'(4 * DW), 32'h0);
      chk("wrap_oor_err", 32'(err[3]), 32'h1);
      access(3, 1'b1, 4'b1001, 32'hFFFF_FFFF, 32'hA5C3_3C5A);
      access(3, 1'b0, 4'h0, 32'hFFFF_FFFC, 32'h0);
      chk("wrap_top_err", 32'(err[3]), 32'h0);
      idle(2);
      // abort: drop cs in the second cycle of a WAIT_CYC=2 write
      cs = '0;
      cs[1] = 1'b1;
      we = 1'b1;
      wem = 4'hF;
      addr = B + 32'd12;
      din = 32'h1234;
      #3;
      chk("abort_hold1", 32'(hold[1]), 32'h1);
      @(posedge clk);
      @(negedge clk);
      #1;
      cs[1] = 1'b0;
      #1;
      chk("abort_hold0", 32'(hold[1]), 32'h0);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("abort_dout", dout[1], exp_dout[1]);
      chk("abort_err", 32'(err[1]), 32'h0);
      access(1, 1'b0, 4'h0, B + 32'd12, 32'h0);
      chk("abort_nowrite", 32'(dout[1] == 32'h1234 && rm[1][3] != 32'h1234), 32'h0);
      idle(1);
      // reset pulse in the middle of a pending WAIT_CYC=2 write
      cs = '0;
      cs[1] = 1'b1;
      we = 1'b1;
      wem = 4'hF;
      addr = B + 32'd12;
      din = 32'h1234;
      @(posedge clk);
      @(negedge clk);
      #1;
      rstn = 1'b0;
      #1;
      chk("rst_mid_hold", 32'(hold[1]), 32'h0);
      for (int j = 0; j < 4; j++) begin
         chk("rst_mid_dout", dout[j], 32'h0);
         chk("rst_mid_err", 32'(err[j]), 32'h0);
         exp_dout[j] = '0;
         last_oor[j] = 1'b0;
      end
      cs = '0;
      #1;
      rstn = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
      access(1, 1'b0, 4'h0, B + 32'd12, 32'h0);
      chk("rst_nowrite", 32'(dout[1] == 32'h1234 && rm[1][3] != 32'h1234), 32'h0);
      idle(1);
      repeat (300) begin
         i = int'($urandom_range(0, 3));
         sel = int'($urandom_range(0, 9));
         a = sel < 7 ? base_of(i) + 32'(4 * $urandom_range(0, DW - 1)) + 32'($urandom_range(0, 3)) :
             sel == 7 ? base_of(i) + 32'(4 * DW) + 32'($urandom_range(0, 3)) :
             sel == 8 ? base_of(i) - 32'd4 + 32'($urandom_range(0, 3)) : $urandom;
         access(i, 1'($urandom_range(0, 1)), 4'($urandom), a, $urandom);
         if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 2)));
      end
      idle(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
